// File: rtl/pdu_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// pdu_dmem_arbiter
//
// Shares the single-port PDU data memory between the CPU data port and the
// PDU debug/host port. Requesters are arbitrated round-robin. While pdu_lock
// is high the PDU owns the memory exclusively. At most one access is issued
// per cycle. The response comes back one cycle later and is tagged by the
// per-requester rvalid.
//
// Optional feature macro: PDU_DMEM_ARB_STATS_EN
//   When this macro is defined, the block adds a stats_clr input and three
//   saturating 32-bit activity counters.
//
// Ports:
//   sys_clk, sys_rst       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request (held until cpu_gnt)
//   cpu_gnt                CPU accepted this cycle (combinational)
//   cpu_rvalid/rdata       CPU response (rvalid registered)
//   pdu_req/we/addr/wdata  PDU request (held until pdu_gnt)
//   pdu_lock               PDU exclusive-access lock
//   pdu_gnt                PDU accepted this cycle (combinational)
//   pdu_rvalid/rdata       PDU response (rvalid registered)
//   mem_addr/wdata/we      memory drive, muxed from the winner
//   mem_rdata              memory read data, valid the cycle after access
//   stats_clr, stat_*_cnt  statistics (only with PDU_DMEM_ARB_STATS_EN)
// ---------------------------------------------------------------------------
module pdu_dmem_arbiter #(
  parameter int DEPTH = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [DEPTH-1:0] cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  input  logic             pdu_req,
  input  logic             pdu_we,
  input  logic [DEPTH-1:0] pdu_addr,
  input  logic [31:0]      pdu_wdata,
  input  logic             pdu_lock,
  output logic             pdu_gnt,
  output logic             pdu_rvalid,
  output logic [31:0]      pdu_rdata,
`ifdef PDU_DMEM_ARB_STATS_EN
  input  logic             stats_clr,
  output logic [31:0]      stat_cpu_cnt,
  output logic [31:0]      stat_pdu_cnt,
  output logic [31:0]      stat_conflict_cnt,
`endif
  output logic [DEPTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic {
    GRANT_CPU = 1'b0,
    GRANT_PDU = 1'b1
  } grant_e;

  grant_e last_grant_q;
  grant_e last_grant_d;
  logic   cpu_gnt_s;
  logic   pdu_gnt_s;
  // Response-owner flags: each one records that its side won in the previous cycle.
  logic   cpu_rvalid_q;
  logic   pdu_rvalid_q;

  // Grant decision. The lock overrides round-robin. On a conflict, the side
  // that did not win last time is granted.
  always_comb begin
    cpu_gnt_s = 1'b0;
    pdu_gnt_s = 1'b0;
    if (pdu_lock) begin
      pdu_gnt_s = pdu_req;
    end else if (cpu_req && pdu_req) begin
      if (last_grant_q == GRANT_PDU) begin
        cpu_gnt_s = 1'b1;
      end else begin
        pdu_gnt_s = 1'b1;
      end
    end else begin
      cpu_gnt_s = cpu_req;
      pdu_gnt_s = pdu_req;
    end
  end

  // Memory drive mux. The CPU values are the idle default, and we stays low unless a grant occurs.
  always_comb begin
    if (pdu_gnt_s) begin
      mem_addr  = pdu_addr;
      mem_wdata = pdu_wdata;
      mem_we    = pdu_we;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_we & cpu_gnt_s;
    end
  end

  // Next round-robin pointer. It only moves when someone is granted.
  always_comb begin
    if (pdu_gnt_s) begin
      last_grant_d = GRANT_PDU;
    end else if (cpu_gnt_s) begin
      last_grant_d = GRANT_CPU;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Arbitration state and one-cycle response tagging.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_grant_q <= GRANT_PDU;
      cpu_rvalid_q <= 1'b0;
      pdu_rvalid_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cpu_rvalid_q <= cpu_gnt_s;
      pdu_rvalid_q <= pdu_gnt_s;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign pdu_gnt    = pdu_gnt_s;
  assign cpu_rvalid = cpu_rvalid_q;
  assign pdu_rvalid = pdu_rvalid_q;
  // The memory returns written data on writes, so both data paths are plain pass-throughs.
  assign cpu_rdata  = mem_rdata;
  assign pdu_rdata  = mem_rdata;

`ifdef PDU_DMEM_ARB_STATS_EN
  logic [31:0] stat_cpu_q;
  logic [31:0] stat_pdu_q;
  logic [31:0] stat_conflict_q;

  // Saturating increment.
  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    if (val == 32'hFFFF_FFFF) begin
      return val;
    end else begin
      return val + 32'd1;
    end
  endfunction

  // Activity counters. A clear wins over a same-cycle increment.
  // A conflict is counted even when the lock blocks the CPU.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stat_cpu_q      <= 32'd0;
      stat_pdu_q      <= 32'd0;
      stat_conflict_q <= 32'd0;
    end else if (stats_clr) begin
      stat_cpu_q      <= 32'd0;
      stat_pdu_q      <= 32'd0;
      stat_conflict_q <= 32'd0;
    end else begin
      if (cpu_gnt_s) begin
        stat_cpu_q <= sat_inc(stat_cpu_q);
      end
      if (pdu_gnt_s) begin
        stat_pdu_q <= sat_inc(stat_pdu_q);
      end
      if (cpu_req && pdu_req) begin
        stat_conflict_q <= sat_inc(stat_conflict_q);
      end
    end
  end

  assign stat_cpu_cnt      = stat_cpu_q;
  assign stat_pdu_cnt      = stat_pdu_q;
  assign stat_conflict_cnt = stat_conflict_q;
`endif

endmodule

// File: tb/tb_pdu_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pdu_dmem_arbiter
//
// Directed bench for pdu_dmem_arbiter. Its memory model has a synchronous
// 1-cycle read and returns the written data on a write.
//
// Timing of the bench:
//   - Inputs change on the falling edge, or 1 time unit after a rising edge.
//   - Grants are sampled 1 time unit after the inputs change.
//   - Responses are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pdu_dmem_arbiter;

  localparam int DEPTH = 12;

  logic             sys_clk;
  logic             sys_rst;
  logic             cpu_req;
  logic             cpu_we;
  logic [DEPTH-1:0] cpu_addr;
  logic [31:0]      cpu_wdata;
  logic             cpu_gnt;
  logic             cpu_rvalid;
  logic [31:0]      cpu_rdata;
  logic             pdu_req;
  logic             pdu_we;
  logic [DEPTH-1:0] pdu_addr;
  logic [31:0]      pdu_wdata;
  logic             pdu_lock;
  logic             pdu_gnt;
  logic             pdu_rvalid;
  logic [31:0]      pdu_rdata;
  logic [DEPTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata;
`ifdef PDU_DMEM_ARB_STATS_EN
  logic             stats_clr;
  logic [31:0]      stat_cpu_cnt;
  logic [31:0]      stat_pdu_cnt;
  logic [31:0]      stat_conflict_cnt;
`endif

  // Backdoor preload port of the memory model.
  logic             pre_en;
  logic [DEPTH-1:0] pre_addr;
  logic [31:0]      pre_data;
  logic [31:0]      mem [0:(1<<DEPTH)-1];

  int vectors;
  int errs;

  pdu_dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .pdu_req    (pdu_req),
    .pdu_we     (pdu_we),
    .pdu_addr   (pdu_addr),
    .pdu_wdata  (pdu_wdata),
    .pdu_lock   (pdu_lock),
    .pdu_gnt    (pdu_gnt),
    .pdu_rvalid (pdu_rvalid),
    .pdu_rdata  (pdu_rdata),
`ifdef PDU_DMEM_ARB_STATS_EN
    .stats_clr         (stats_clr),
    .stat_cpu_cnt      (stat_cpu_cnt),
    .stat_pdu_cnt      (stat_pdu_cnt),
    .stat_conflict_cnt (stat_conflict_cnt),
`endif
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // 10-unit clock.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Single-port memory: 1-cycle read, and a write returns the written data.
  always @(posedge sys_clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors   = 0;
    errs      = 0;
    sys_rst   = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = 32'd0;
    pdu_req   = 1'b0;
    pdu_we    = 1'b0;
    pdu_addr  = '0;
    pdu_wdata = 32'd0;
    pdu_lock  = 1'b0;
    pre_en    = 1'b1;
    pre_addr  = 12'h010;
    pre_data  = 32'hDEAD_BEEF;
`ifdef PDU_DMEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset state (the preload happens during reset).
    @(posedge sys_clk);
    #1;
    pre_en = 1'b0;
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_pdu_rvalid", {31'd0, pdu_rvalid}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;

    // CPU-only read of 0x010.
    @(negedge sys_clk);
    cpu_req  = 1'b1;
    cpu_addr = 12'h010;
    #1;
    chk("t1_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("t1_pdu_gnt", {31'd0, pdu_gnt}, 32'd0);
    chk("t1_mem_addr", {20'd0, mem_addr}, 32'h010);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge sys_clk);
    #1;
    cpu_req = 1'b0;
    chk("t1_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("t1_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_pdu_rvalid", {31'd0, pdu_rvalid}, 32'd0);
    @(posedge sys_clk);
    #1;
    chk("t1_cpu_rvalid_off", {31'd0, cpu_rvalid}, 32'd0);

    // PDU write of 0x12345678 to 0x020, then a read back.
    @(negedge sys_clk);
    pdu_req   = 1'b1;
    pdu_we    = 1'b1;
    pdu_addr  = 12'h020;
    pdu_wdata = 32'h1234_5678;
    #1;
    chk("t2_pdu_gnt_w", {31'd0, pdu_gnt}, 32'd1);
    chk("t2_mem_we_w", {31'd0, mem_we}, 32'd1);
    chk("t2_mem_wdata", mem_wdata, 32'h1234_5678);
    @(posedge sys_clk);
    #1;
    pdu_we = 1'b0;
    chk("t2_pdu_rvalid_w", {31'd0, pdu_rvalid}, 32'd1);
    chk("t2_pdu_rdata_w", pdu_rdata, 32'h1234_5678);
    chk("t2_cpu_rvalid_w", {31'd0, cpu_rvalid}, 32'd0);
    #1;
    chk("t2_pdu_gnt_r", {31'd0, pdu_gnt}, 32'd1);
    chk("t2_mem_we_r", {31'd0, mem_we}, 32'd0);
    @(posedge sys_clk);
    #1;
    pdu_req = 1'b0;
    chk("t2_pdu_rvalid_r", {31'd0, pdu_rvalid}, 32'd1);
    chk("t2_pdu_rdata_r", pdu_rdata, 32'h1234_5678);

    // Reset pulse, then continuous conflict: C,P,C,P,... expected.
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 12'h010;
    pdu_req  = 1'b1;
    pdu_we   = 1'b0;
    pdu_addr = 12'h020;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_pdu_gnt_%0d", i), {31'd0, pdu_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t3_both_gnt_%0d", i), {31'd0, cpu_gnt & pdu_gnt}, 32'd0);
      @(posedge sys_clk);
      #1;
      chk($sformatf("t3_cpu_rvalid_%0d", i), {31'd0, cpu_rvalid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t3_pdu_rvalid_%0d", i), {31'd0, pdu_rvalid}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t3_rdata_%0d", i), cpu_rdata,
          (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
    end

    // Lock with both requesting: PDU only. Release: CPU is next.
    pdu_lock = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_lock_cpu_gnt_%0d", i), {31'd0, cpu_gnt}, 32'd0);
      chk($sformatf("t4_lock_pdu_gnt_%0d", i), {31'd0, pdu_gnt}, 32'd1);
      @(posedge sys_clk);
      #1;
      chk($sformatf("t4_lock_pdu_rvalid_%0d", i), {31'd0, pdu_rvalid}, 32'd1);
    end
    pdu_lock = 1'b0;
    #1;
    chk("t4_unlock_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("t4_unlock_pdu_gnt", {31'd0, pdu_gnt}, 32'd0);
    @(posedge sys_clk);
    #1;
    // Locking while the CPU response is in flight must not cancel it.
    pdu_lock = 1'b1;
    #1;
    chk("t4_relock_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("t4_relock_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t4_relock_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    chk("t4_relock_pdu_gnt", {31'd0, pdu_gnt}, 32'd1);
    @(negedge sys_clk);
    pdu_lock = 1'b0;
    cpu_req  = 1'b0;
    pdu_req  = 1'b0;
    @(posedge sys_clk);
    #1;

    // Reset in the cycle after a CPU read grant. The last grant was the CPU,
    // so a CPU-first grant afterwards shows that the reset restored priority.
    @(negedge sys_clk);
    cpu_req = 1'b1;
    #1;
    chk("t5_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    @(posedge sys_clk);
    #1;
    cpu_req = 1'b0;
    chk("t5_cpu_rvalid_pre", {31'd0, cpu_rvalid}, 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("t5_cpu_rvalid_async", {31'd0, cpu_rvalid}, 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    cpu_req = 1'b1;
    pdu_req = 1'b1;
    #1;
    chk("t5_post_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
    chk("t5_post_pdu_gnt", {31'd0, pdu_gnt}, 32'd0);
    @(posedge sys_clk);
    #1;
    chk("t5_post_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    cpu_req = 1'b0;
    pdu_req = 1'b0;

`ifdef PDU_DMEM_ARB_STATS_EN
    // Three conflict cycles (C,P,C), then one PDU-only grant (P).
    @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("s_rst_cpu", stat_cpu_cnt, 32'd0);
    cpu_req = 1'b1;
    pdu_req = 1'b1;
    repeat (3) @(negedge sys_clk);
    cpu_req = 1'b0;
    @(negedge sys_clk);
    pdu_req = 1'b0;
    #1;
    chk("s_cpu_cnt", stat_cpu_cnt, 32'd2);
    chk("s_pdu_cnt", stat_pdu_cnt, 32'd2);
    chk("s_conflict_cnt", stat_conflict_cnt, 32'd3);
    @(negedge sys_clk);
    stats_clr = 1'b1;
    cpu_req   = 1'b1;
    pdu_req   = 1'b1;
    @(negedge sys_clk);
    stats_clr = 1'b0;
    cpu_req   = 1'b0;
    pdu_req   = 1'b0;
    #1;
    chk("s_clr_cpu", stat_cpu_cnt, 32'd0);
    chk("s_clr_pdu", stat_pdu_cnt, 32'd0);
    chk("s_clr_conflict", stat_conflict_cnt, 32'd0);
`endif

    @(posedge sys_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/pdu_dmem_arbiter.md
Name: pdu_dmem_arbiter

Overview:
- Shares the single-port PDU data memory between two requesters: the CPU data port and the PDU debug/host port.
- Round-robin arbitration, with a PDU lock override for debug sessions.
- Issues at most one memory access per cycle.
- Drives the memory's address/wdata/we inputs and returns read data, tagged per requester, one cycle later.
- Sits between the CPU/PDU bus logic and the data memory. The memory has a synchronous 1-cycle read, and on a write it returns the written data.

Parameters:
DEPTH, 12, memory word-address width (memory holds 2^DEPTH 32-bit words)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request; held until cpu_gnt
cpu_we  in  1  CPU write enable (qualified by cpu_req)
cpu_addr  in  DEPTH  CPU word address
cpu_wdata  in  32  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle (combinational)
cpu_rvalid  out  1  CPU response valid (registered)
cpu_rdata  out  32  CPU response data
pdu_req  in  1  PDU access request; held until pdu_gnt
pdu_we  in  1  PDU write enable
pdu_addr  in  DEPTH  PDU word address
pdu_wdata  in  32  PDU write data
pdu_lock  in  1  PDU exclusive-access lock
pdu_gnt  out  1  PDU access accepted this cycle (combinational)
pdu_rvalid  out  1  PDU response valid (registered)
pdu_rdata  out  32  PDU response data
mem_addr  out  DEPTH  memory address
mem_wdata  out  32  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  32  memory read data (valid the cycle after access)

Behaviour:
- Reset (async, sys_rst=1):
  - cpu_rvalid=0, pdu_rvalid=0.
  - last_grant register = PDU, so CPU wins the first conflict.
  - Response-owner register cleared.
- Grant logic (combinational, same cycle):
  - Only one requester active: that requester is granted, unless blocked by the lock.
  - Both requesting: grant the side not equal to last_grant.
  - pdu_lock=1: cpu_gnt forced 0; a PDU request is always granted; CPU waits.
  - At most one of cpu_gnt/pdu_gnt is high in any cycle.
  - Neither granted: mem_we=0; mem_addr/mem_wdata hold the CPU values (don't-care).
- Memory drive:
  - mem_addr/mem_wdata/mem_we are muxed from the winner in the grant cycle.
  - mem_we = winner_we AND grant.
- last_grant updates on the clock edge only when a grant occurs.
- Response, 1-cycle latency:
  - A grant at cycle T sets the winner's rvalid=1 at T+1 for exactly one cycle.
  - Both reads and writes produce a response; a write returns the written data.
  - cpu_rdata and pdu_rdata both pass mem_rdata through; they are meaningful only while the matching rvalid=1.
  - Back-to-back grants give back-to-back rvalids with no bubble.
- No response backpressure: a requester must accept rvalid when it fires.
- Requester rules:
  - req/we/addr/wdata stay stable until gnt.
  - A new request may be presented in the cycle after gnt.
  - Dropping req before gnt is legal; no access occurs.
- Reset mid-operation:
  - Any pending rvalid is cancelled; the in-flight memory write may or may not complete.
  - Arbitration restarts with CPU priority.
- Lock edges:
  - Asserting pdu_lock while a CPU response is in flight does not cancel that response.
  - Deasserting pdu_lock restores round-robin using the current last_grant.

Optional Feature:
PDU_DMEM_ARB_STATS_EN
- Defined: adds input stats_clr (1) and outputs stat_cpu_cnt, stat_pdu_cnt, stat_conflict_cnt (32 each).
  - stat_cpu_cnt/stat_pdu_cnt increment per grant to that side.
  - stat_conflict_cnt increments in each cycle where both req=1, including lock-blocked CPU cycles.
  - All counters saturate at 0xFFFFFFFF.
  - Counters reset to 0 on sys_rst; stats_clr clears them synchronously and takes precedence over increment.
- Undefined: these ports and registers do not exist; arbitration behaviour is identical.

Test Plan:
- CPU-only read:
  - Stimulus: memory preloaded addr 0x010=0xDEADBEEF; cpu_req=1, cpu_we=0, cpu_addr=0x010.
  - Expect: cpu_gnt=1 same cycle; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF next cycle; pdu_rvalid=0.
- PDU write then read:
  - Stimulus: PDU writes 0x12345678 to 0x020, then reads 0x020.
  - Expect: write response data 0x12345678; mem_we=1 in the grant cycle only; read returns 0x12345678.
- Simultaneous continuous requests after reset:
  - Expect: grants alternate CPU, PDU, CPU, PDU for 8 cycles.
  - Expect: every cycle has exactly one rvalid after the first; no cycle has both gnt high.
- Lock:
  - Stimulus: pdu_lock=1 with both requesting for 5 cycles.
  - Expect: 5 PDU grants, cpu_gnt=0 throughout.
  - Stimulus: release lock.
  - Expect: CPU granted the next cycle.
- Reset mid-access:
  - Stimulus: assert sys_rst in the cycle after a CPU read grant.
  - Expect: cpu_rvalid drops to 0 immediately (async); after release, both requesting gives a CPU grant first.
- Stats (macro defined):
  - Stimulus: 3 conflict cycles plus 1 PDU-only grant.
  - Expect: cpu=2, pdu=2, conflict=3.
  - Stimulus: stats_clr=1 together with a grant.
  - Expect: all counters read 0 next cycle.
